sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//   Parametrised single-clock FIFO, successor to the basic sync FIFO.
//   Adds: fill-level output, programmable almost-full/almost-empty flags, sticky overflow/underflow
//   error flags with clear, correct simultaneous read/write count handling, and selectable
//   standard or first-word-fall-through (FWFT) read mode.
//   Sits between producer/consumer stages on one clock domain, e.g. datapath elastic buffering.
// PARAMETERS
//   DATA_WIDTH  8           data word width in bits (>=1)
//   DEPTH       16          number of entries; power of two, >=2
//   AF_THRESH   DEPTH-2     almost_full asserted when level >= AF_THRESH (1..DEPTH)
//   AE_THRESH   2           almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)
//   FWFT        0           0 = standard registered read; 1 = first-word-fall-through
// PORTS
//   clk           in   1                 clock, all logic on rising edge
//   rst           in   1                 synchronous reset, active-high
//   wr_en         in   1                 write request
//   din           in   DATA_WIDTH        write data
//   rd_en         in   1                 read request (FWFT: pop/acknowledge head)
//   clr_err       in   1                 clears overflow/underflow
//   dout          out  DATA_WIDTH        read data
//   dout_valid    out  1                 dout holds valid data (see BEHAVIOUR)
//   full          out  1                 level == DEPTH
//   empty         out  1                 level == 0
//   almost_full   out  1                 level >= AF_THRESH
//   almost_empty  out  1                 level <= AE_THRESH
//   level         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   overflow      out  1                 sticky: write attempted while full
//   underflow     out  1                 sticky: read attempted while empty
// BEHAVIOUR
// - Reset (rst=1 at clk edge): ptrs, level, dout, dout_valid, overflow, underflow <= 0; memory
//   contents not cleared. After reset: empty=1, almost_empty=1, full=0, almost_full=0.
//   Reset has priority over all other inputs; mid-operation reset discards all stored data.
// - Pointers: $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0. Flags decoded from registered level only.
// - Write accepted iff wr_en && !full (full as at start of cycle): mem[wr_ptr]<=din, wr_ptr++.
// - Read accepted iff rd_en && !empty (start of cycle): rd_ptr++.
// - Level update: +1 write only, -1 read only, unchanged when both accepted.
//   Full + wr_en + rd_en: read accepted, write rejected, overflow set, level -> DEPTH-1.
//   Empty + wr_en + rd_en: write accepted, read rejected, underflow set, level -> 1.
// - overflow/underflow: set on rejected request, held until clr_err=1; if set and clr_err
//   occur in same cycle, set wins (flag stays 1).
// - FWFT=0: on accepted read, dout <= mem[rd_ptr] next edge (1-cycle latency), dout_valid=1 for
//   exactly that cycle; otherwise dout holds last value, dout_valid=0.
// - FWFT=1: dout = mem[rd_ptr] (combinational from memory), dout_valid = !empty; rd_en pops head,
//   next entry visible the following cycle. Written word visible the cycle after write (no bypass).
// - Data order strictly FIFO; no data loss on accepted requests.
// TESTING
// 1 Reset: rst=1 two cycles -> empty=1, full=0, level=0, dout=0, overflow=underflow=0.
// 2 Fill/drain DEPTH=16: write 0x00..0x0F -> full=1 at level 16, almost_full from level 14;
//   read 16 -> data 0x00..0x0F in order, FWFT=0 each 1 cycle after rd_en, empty=1 at end.
// 3 Wrap: write 10, read 10, write 16, read 16 -> order preserved across pointer wrap, no errors.
// 4 Full+wr+rd: at level 16, wr_en=rd_en=1 din=0xAA -> head read, 0xAA dropped, overflow=1,
//   level=15; clr_err=1 -> overflow=0.
// 5 Empty+wr+rd: level 0, wr_en=rd_en=1 din=0x55 -> underflow=1, level=1, next read returns 0x55.
// 6 FWFT=1: write 0x3C -> next cycle dout=0x3C, dout_valid=1; rd_en=1 -> empty=1, dout_valid=0;
//   rst asserted at level 5 -> level=0 next cycle, dout_valid=0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with a fill-level output, programmable almost-full/almost-empty flags,
// sticky overflow/underflow error flags, and a choice of registered or fall-through read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_WIDTH-1:0]      dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic [LW-1:0]         level_next;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  wr_acc;
    logic                  rd_acc;

    // All flags come from the registered level, so they reflect start-of-cycle occupancy.
    assign full         = (level_reg == LW'(DEPTH));
    assign empty        = (level_reg == '0);
    assign almost_full  = (level_reg >= LW'(AF_THRESH));
    assign almost_empty = (level_reg <= LW'(AE_THRESH));
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        level_next = level_reg;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage has no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            // A new error event in the same cycle as clr_err keeps the flag set.
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end else if (clr_err) begin
                overflow_reg <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow_reg <= 1'b1;
            end else if (clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] dout_reg;
            logic                  dout_valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg       <= '0;
                    dout_valid_reg <= 1'b0;
                end else begin
                    dout_valid_reg <= rd_acc;
                    if (rd_acc) begin
                        dout_reg <= mem[rd_ptr_reg];
                    end
                end
            end

            assign dout       = dout_reg;
            assign dout_valid = dout_valid_reg;
        end else begin : g_fwft
            // Head of queue is presented directly; a fresh write shows up once level_reg counts it.
            assign dout       = mem[rd_ptr_reg];
            assign dout_valid = !empty;
        end
    endgenerate

endmodule
